// File: rtl/clint_pkg.sv
// Purpose: shared CLINT definitions -- register offsets, bus FSM states, byte-merge helper.
// Latency: n/a (package only).
// Backpressure: n/a.
// Build option: CLINT_PRESCALE_EN (consumed by clint_timer) enables the mtime prescaler.
package clint_pkg;

  // Register offsets relative to the CLINT base address.
  localparam logic [63:0] CLINT_MSIP     = 64'h0000_0000_0000_0000;
  localparam logic [63:0] CLINT_MTIMECMP = 64'h0000_0000_0000_4000;
  localparam logic [63:0] CLINT_MTIME    = 64'h0000_0000_0000_BFF8;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  // Replace only the bytes of old_val selected by strobe with the bytes of new_val.
  function automatic logic [63:0] byte_merge(input logic [63:0] old_val,
                                             input logic [63:0] new_val,
                                             input logic [7:0]  strobe);
    logic [63:0] r;
    r = old_val;
    for (int i = 0; i < 8; i++) begin
      if (strobe[i]) r[i*8 +: 8] = new_val[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/clint_timer.sv
// Purpose: mtime counter, mtimecmp register and registered timer-interrupt compare.
// Latency: writes visible the cycle after *_we; trint lags the registers by one cycle.
// Backpressure: none; write strobes are always accepted.
// Ports: clk/reset (sync, active-high); mtime_we/mtime_wdata and mtimecmp_we/mtimecmp_wdata
//        load full 64-bit values; mtime/mtimecmp expose current values; trint = mtime >= mtimecmp.
// Build option: CLINT_PRESCALE_EN -- tick mtime once every TICK_DIV cycles instead of every cycle.
module clint_timer #(
  parameter int TICK_DIV = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mtime_we,
  input  logic [63:0] mtime_wdata,
  input  logic        mtimecmp_we,
  input  logic [63:0] mtimecmp_wdata,
  output logic [63:0] mtime,
  output logic [63:0] mtimecmp,
  output logic        trint
);

  if (TICK_DIV < 1) begin : g_bad_tick_div
    $error("clint_timer: TICK_DIV must be at least 1");
  end

  logic tick;

`ifdef CLINT_PRESCALE_EN
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre_cnt;

  assign tick = (pre_cnt == PRE_LAST);

  // An mtime write restarts the prescale period so the new value lasts a full tick.
  always_ff @(posedge clk) begin
    if (reset)                 pre_cnt <= '0;
    else if (mtime_we || tick) pre_cnt <= '0;
    else                       pre_cnt <= pre_cnt + PW'(1);
  end
`else
  assign tick = 1'b1;
`endif

  // A software write wins over the increment in the same cycle.
  always_ff @(posedge clk) begin
    if (reset)         mtime <= '0;
    else if (mtime_we) mtime <= mtime_wdata;
    else if (tick)     mtime <= mtime + 64'd1;
  end

  always_ff @(posedge clk) begin
    if (reset)            mtimecmp <= '1;
    else if (mtimecmp_we) mtimecmp <= mtimecmp_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) trint <= 1'b0;
    else       trint <= (mtime >= mtimecmp);
  end

endmodule

// File: rtl/clint.sv
// Purpose: core-local interruptor -- bus slave FSM, msip register, mtime/mtimecmp via clint_timer.
// Latency: request accepted combinationally in IDLE; response exactly one cycle later.
// Backpressure: resp_addr_ok is low while a response is pending; requester holds req_* until accepted.
// Ports: clk/reset (sync, active-high); req_valid/req_addr/req_write/req_strobe/req_data bus request;
//        resp_addr_ok accept, resp_data_ok/resp_data response; swint/trint interrupts to csr.
// Build option: CLINT_PRESCALE_EN -- mtime ticks every TICK_DIV cycles (see clint_timer).
module clint
  import clint_pkg::*;
#(
  parameter logic [63:0] BASE     = 64'h0200_0000,
  parameter int          TICK_DIV = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [63:0] req_addr,
  input  logic        req_write,
  input  logic [7:0]  req_strobe,
  input  logic [63:0] req_data,
  output logic        resp_addr_ok,
  output logic        resp_data_ok,
  output logic [63:0] resp_data,
  output logic        swint,
  output logic        trint
);

  localparam logic [63:0] ADDR_MSIP     = BASE + CLINT_MSIP;
  localparam logic [63:0] ADDR_MTIMECMP = BASE + CLINT_MTIMECMP;
  localparam logic [63:0] ADDR_MTIME    = BASE + CLINT_MTIME;

  state_t      state, state_nxt;
  logic [63:0] addr_q, data_q, rdata_q, rd_val;
  logic        write_q;
  logic [7:0]  strobe_q;
  logic        msip;
  logic        do_write;
  logic [63:0] mtime, mtimecmp;

  // Reset gates both handshake outputs so an aborted transaction never signals completion.
  always_comb begin
    state_nxt    = state;
    resp_addr_ok = 1'b0;
    resp_data_ok = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && !reset) begin
          resp_addr_ok = 1'b1;
          state_nxt    = RESP;
        end
      end
      RESP: begin
        resp_data_ok = !reset;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    rd_val = '0;
    if (req_addr == ADDR_MSIP)          rd_val = {63'd0, msip};
    else if (req_addr == ADDR_MTIMECMP) rd_val = mtimecmp;
    else if (req_addr == ADDR_MTIME)    rd_val = mtime;
  end

  // Read data is captured at the accept edge; writes return zero data.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= '0;
      data_q   <= '0;
      write_q  <= 1'b0;
      strobe_q <= '0;
      rdata_q  <= '0;
    end else if (resp_addr_ok) begin
      addr_q   <= req_addr;
      data_q   <= req_data;
      write_q  <= req_write;
      strobe_q <= req_strobe;
      rdata_q  <= req_write ? 64'd0 : rd_val;
    end
  end

  assign resp_data = resp_data_ok ? rdata_q : 64'd0;

  // Writes commit at the end of the RESP cycle.
  assign do_write = (state == RESP) && write_q && !reset;

  always_ff @(posedge clk) begin
    if (reset) msip <= 1'b0;
    else if (do_write && (addr_q == ADDR_MSIP) && strobe_q[0]) msip <= data_q[0];
  end

  always_ff @(posedge clk) begin
    if (reset) swint <= 1'b0;
    else       swint <= msip;
  end

  clint_timer #(
    .TICK_DIV(TICK_DIV)
  ) u_timer (
    .clk           (clk),
    .reset         (reset),
    .mtime_we      (do_write && (addr_q == ADDR_MTIME)),
    .mtime_wdata   (byte_merge(mtime, data_q, strobe_q)),
    .mtimecmp_we   (do_write && (addr_q == ADDR_MTIMECMP)),
    .mtimecmp_wdata(byte_merge(mtimecmp, data_q, strobe_q)),
    .mtime         (mtime),
    .mtimecmp      (mtimecmp),
    .trint         (trint)
  );

endmodule

// File: tb/tb_clint.sv
// Purpose: self-checking bench for clint; directed bus transactions with a response scoreboard.
// Latency: checks the one-cycle accept-to-response timing and interrupt register lag.
// Backpressure: driver holds each request until resp_addr_ok, bounded by a cycle budget.
module tb_clint;

  localparam logic [63:0] BASE = 64'h0200_0000;
`ifdef CLINT_PRESCALE_EN
  localparam int TDIV = 4;
`else
  localparam int TDIV = 10;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [63:0] req_addr = '0;
  logic        req_write = 1'b0;
  logic [7:0]  req_strobe = '0;
  logic [63:0] req_data = '0;
  logic        resp_addr_ok, resp_data_ok, swint, trint;
  logic [63:0] resp_data;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];
  logic prev_acc = 1'b0;

  always #5 clk = ~clk;

  clint #(.BASE(BASE), .TICK_DIV(TDIV)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_write   (req_write),
    .req_strobe  (req_strobe),
    .req_data    (req_data),
    .resp_addr_ok(resp_addr_ok),
    .resp_data_ok(resp_data_ok),
    .resp_data   (resp_data),
    .swint       (swint),
    .trint       (trint)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every response and checks response timing.
  always @(negedge clk) begin
    if (prev_acc && !reset) check("resp_one_cycle_after_accept", {63'd0, resp_data_ok}, 64'd1);
    if (resp_data_ok) begin
      check("resp_has_prior_accept", {63'd0, prev_acc}, 64'd1);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL resp_unexpected: got response %h, expected none at %0t", resp_data, $time);
      end else begin
        check("resp_data", resp_data, exp_q.pop_front());
      end
    end else begin
      check("resp_data_zero_when_idle", resp_data, 64'd0);
    end
    prev_acc = resp_addr_ok;
  end

  // Drive one request, wait for acceptance, then return one cycle after the response cycle.
  task automatic issue(input bit wr, input logic [63:0] off, input logic [7:0] strb,
                       input logic [63:0] d, input logic [63:0] exp);
    int n;
    req_valid  = 1'b1;
    req_write  = wr;
    req_addr   = BASE + off;
    req_strobe = strb;
    req_data   = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_addr_ok && n < 8);
    if (!resp_addr_ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got no resp_addr_ok, expected accept within 8 cycles");
    end else begin
      exp_q.push_back(exp);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = 1'b1;
    req_addr  = BASE + 64'hBFF8;
    req_write = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_addr_ok", {63'd0, resp_addr_ok}, 64'd0);
    check("reset_data_ok", {63'd0, resp_data_ok}, 64'd0);
    check("reset_swint", {63'd0, swint}, 64'd0);
    check("reset_trint", {63'd0, trint}, 64'd0);
    @(posedge clk); #1;
    reset     = 1'b0;
    req_valid = 1'b0;
  endtask

  initial begin
    do_reset();
`ifdef CLINT_PRESCALE_EN
    repeat (16) @(posedge clk);
    #1;
    issue(1'b0, 64'hBFF8, 8'h00, 64'd0, 64'd4);
`else
    // mtime after five idle cycles
    repeat (5) @(posedge clk);
    #1;
    issue(1'b0, 64'hBFF8, 8'h00, 64'd0, 64'd5);

    // msip / swint under strobes
    issue(1'b1, 64'h0000, 8'h01, 64'd1, 64'd0);
    @(posedge clk); #1;
    check("swint_set", {63'd0, swint}, 64'd1);
    issue(1'b1, 64'h0000, 8'h00, 64'd0, 64'd0);
    @(posedge clk); #1;
    check("swint_strobe0_keeps_1", {63'd0, swint}, 64'd1);
    issue(1'b1, 64'h0000, 8'h01, 64'd0, 64'd0);
    @(posedge clk); #1;
    check("swint_clear", {63'd0, swint}, 64'd0);
    issue(1'b1, 64'h0000, 8'h00, 64'd1, 64'd0);
    @(posedge clk); #1;
    check("swint_strobe0_keeps_0", {63'd0, swint}, 64'd0);
    issue(1'b1, 64'h0000, 8'hFF, '1, 64'd0);
    issue(1'b0, 64'h0000, 8'h00, 64'd0, 64'd1);

    // mtimecmp = 20 with mtime restarted at 0
    issue(1'b1, 64'hBFF8, 8'hFF, 64'd0, 64'd0);
    issue(1'b1, 64'h4000, 8'hFF, 64'd20, 64'd0);
    repeat (18) @(posedge clk);
    #1;
    check("trint_before_match", {63'd0, trint}, 64'd0);
    @(posedge clk); #1;
    check("trint_at_match", {63'd0, trint}, 64'd1);
    issue(1'b1, 64'h4000, 8'hFF, '1, 64'd0);
    check("trint_lags_cmp_write", {63'd0, trint}, 64'd1);
    @(posedge clk); #1;
    check("trint_cleared", {63'd0, trint}, 64'd0);

    // byte-merged mtimecmp, then mtime wrap with unsigned compare
    issue(1'b1, 64'h4000, 8'hFF, 64'd10, 64'd0);
    issue(1'b1, 64'h4000, 8'hF0, 64'hAAAA_BBBB_CCCC_DDDD, 64'd0);
    issue(1'b0, 64'h4000, 8'h00, 64'd0, 64'hAAAA_BBBB_0000_000A);
    issue(1'b1, 64'hBFF8, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0);
    issue(1'b0, 64'hBFF8, 8'h00, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE);
    check("trint_high_mtime", {63'd0, trint}, 64'd1);
    issue(1'b0, 64'hBFF8, 8'h00, 64'd0, 64'd0);
    check("trint_after_wrap", {63'd0, trint}, 64'd0);
    issue(1'b0, 64'hBFF8, 8'h00, 64'd0, 64'd2);

    // unmapped accesses still complete
    issue(1'b0, 64'h1000, 8'h00, 64'd0, 64'd0);
    issue(1'b1, 64'h1000, 8'hFF, '1, 64'd0);

    // reset while a write is in RESP: no response, FSM back to IDLE
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_addr   = BASE;
    req_strobe = 8'h01;
    req_data   = 64'd1;
    @(negedge clk);
    check("abort_accept", {63'd0, resp_addr_ok}, 64'd1);
    @(posedge clk); #1;
    reset     = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    check("abort_no_data_ok", {63'd0, resp_data_ok}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    issue(1'b0, 64'hBFF8, 8'h00, 64'd0, 64'd5);
    issue(1'b0, 64'h0000, 8'h00, 64'd0, 64'd0);
    check("abort_swint", {63'd0, swint}, 64'd0);
`endif
    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL responses_missing: got %0d outstanding, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion, expected finish within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/clint.md
CLINT -- requirements
Module: clint

Interface
REQ-001 SHALL have parameter BASE, default 64'h0200_0000, CLINT region base address.
REQ-002 SHALL have parameter TICK_DIV, default 10, cycles per mtime tick; used only when CLINT_PRESCALE_EN is defined.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port req_valid, input, 1, bus request present.
REQ-006 SHALL have port req_addr, input, 64, byte address, 8-byte aligned.
REQ-007 SHALL have port req_write, input, 1, 1 = write, 0 = read.
REQ-008 SHALL have port req_strobe, input, 8, per-byte write enable.
REQ-009 SHALL have port req_data, input, 64, write data.
REQ-010 SHALL have port resp_addr_ok, output, 1, request accepted this cycle.
REQ-011 SHALL have port resp_data_ok, output, 1, response valid this cycle.
REQ-012 SHALL have port resp_data, output, 64, read data, valid with resp_data_ok.
REQ-013 SHALL have port swint, output, 1, machine software interrupt pending, to csr.
REQ-014 SHALL have port trint, output, 1, machine timer interrupt pending, to csr.

Function
REQ-015 SHALL decode offsets from BASE: msip +0x0000, mtimecmp +0x4000, mtime +0xBFF8; any other offset is unmapped.
REQ-016 SHALL use FSM states IDLE and RESP: IDLE with req_valid asserts resp_addr_ok combinationally, latches addr/write/strobe/data, goes to RESP; RESP asserts resp_data_ok for exactly one cycle, then returns to IDLE.
REQ-017 SHALL keep read latency at exactly one cycle after acceptance; resp_data holds register value sampled at the accept edge; resp_data = 0 when resp_data_ok = 0.
REQ-018 SHALL ignore req_valid in RESP (resp_addr_ok = 0); the requester holds the request until accepted.
REQ-019 SHALL apply writes in the RESP cycle, byte-merged under the latched strobe.
REQ-020 SHALL implement msip as 1 bit (data bit 0, strobe bit 0); reads return 63 zero upper bits.
REQ-021 SHALL have unmapped reads return 0 and unmapped writes take no effect, with the handshake still completed.
REQ-022 SHALL increment mtime by 1 each tick; wraps from 64'hFFFF_FFFF_FFFF_FFFF to 0.
REQ-023 SHALL give a same-cycle mtime write precedence over the increment; the written value appears the next cycle with no increment applied.
REQ-024 SHALL register trint = (mtime >= mtimecmp), unsigned 64-bit, evaluated on the current register values, i.e. one cycle behind them.
REQ-025 SHALL drive swint = msip, registered.
REQ-026 SHALL require software to clear trint by writing mtimecmp; no other clear path exists.

Reset
REQ-027 SHALL reset, when reset=1 at a clock edge, state to IDLE, mtime = 0, mtimecmp = all ones, msip = 0, prescaler = 0, swint = 0, trint = 0, resp_addr_ok = 0, resp_data_ok = 0.
REQ-028 SHALL abort any in-flight transaction on reset: no resp_data_ok and no write performed.

Configuration
REQ-029 SHALL, with CLINT_PRESCALE_EN defined, tick mtime once every TICK_DIV cycles from a prescale counter that counts 0..TICK_DIV-1; an mtime write also clears the prescaler.
REQ-030 SHALL, without CLINT_PRESCALE_EN, tick mtime every cycle with no prescaler logic; TICK_DIV is unused.

Structure
REQ-031 SHALL place offset constants (CLINT_MSIP, CLINT_MTIMECMP, CLINT_MTIME) and the FSM state enum in clint_pkg.
REQ-032 SHALL place the mtime counter, prescaler and compare in sub-module clint_timer; clint holds the bus FSM and msip.

Verification
REQ-033 Bench SHALL check: reset, then read BASE+0xBFF8 after 5 idle cycles -> resp_data = 5 (prescale off), and resp_data_ok exactly 1 cycle after resp_addr_ok.
REQ-034 Bench SHALL check: write mtimecmp = 20 with mtime near 0 -> trint rises in the cycle after mtime reaches 20; writing mtimecmp = 64'hFFFF... clears it next cycle.
REQ-035 Bench SHALL check: write msip data 1, strobe 8'h01 -> swint = 1; write data 0 -> swint = 0; write with strobe 8'h00 -> unchanged.
REQ-036 Bench SHALL check: write mtime = 64'hFFFF_FFFF_FFFF_FFFE -> next reads wrap to 0 and continue counting; trint follows the unsigned compare.
REQ-037 Bench SHALL check: read BASE+0x1000 -> resp_data = 0, handshake completes; assert reset during RESP -> no resp_data_ok, state IDLE.
REQ-038 Bench SHALL check: with CLINT_PRESCALE_EN and TICK_DIV = 4, after 16 cycles from reset mtime = 4.
